store_drain_wcb: RTL and testbench
==================================

Name: store_drain_wcb

Overview:
- Downstream consumer of the SM LSU store queue.
- Pops committed stores (64-bit words) from the queue head and merges consecutive stores to the same line into one write-combining buffer.
- Issues line-granular write requests (data + byte mask) to the L1 data cache over a valid/ready handshake.
- Single-entry buffer; merge window closes on line change, full line, explicit flush, or idle timeout.

Parameters:
- ADDR_W, 40, byte address width.
- DATA_W, 64, store word width; fixed at 64 (8 bytes).
- WORDS_PER_LINE, 4, words per line; power of 2, >=2.
- FLUSH_TIMEOUT, 16, idle MERGE cycles before a forced issue; >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- sq_valid  in  1  store queue head valid (queue non-empty)
- sq_addr  in  ADDR_W  head store byte address; bits [2:0] ignored
- sq_data  in  DATA_W  head store data
- sq_pop  out  1  combinational; head consumed this cycle
- flush_req  in  1  level; close the merge window now
- l1_req_valid  out  1  line write request valid
- l1_req_addr  out  ADDR_W  line-aligned address; low log2(WORDS_PER_LINE)+3 bits zero
- l1_req_data  out  WORDS_PER_LINE*DATA_W  line data; word i at [i*64 +: 64]
- l1_req_mask  out  WORDS_PER_LINE*8  byte enables
- l1_req_ready  in  1  L1 accepts request
- drain_idle  out  1  combinational; 1 iff state==IDLE (buffer empty)

Behaviour:
- Decode: widx = sq_addr[3 +: log2(WORDS_PER_LINE)]; tag = sq_addr[ADDR_W-1 : 3+log2(WORDS_PER_LINE)].
- Reset (async): state=IDLE; tag, data, mask, timer = 0. Outputs: l1_req_valid=0, l1_req_addr/data/mask=0, sq_pop=0 (sq_valid low), drain_idle=1.
- IDLE:
  - sq_valid=1 → sq_pop=1; load tag, word[widx]=sq_data, mask byte lane group widx=8'hFF (others 0), timer=0; go MERGE.
  - flush_req is ignored in IDLE.
- MERGE, priority order:
  1. flush_req=1 → sq_pop=0; go ISSUE.
  2. sq_valid=1 with a different tag → sq_pop=0; go ISSUE (the store stays at the queue head).
  3. sq_valid=1 with the same tag → sq_pop=1; word[widx]=sq_data (later store overwrites earlier); set its mask bits; timer=0. If the mask becomes all-ones, go ISSUE; else stay in MERGE.
  4. No sq_valid → timer+1. If timer==FLUSH_TIMEOUT-1, go ISSUE.
- ISSUE:
  - l1_req_valid=1; addr = {tag, zeros}; data and mask from the buffer. Request fields are held stable while valid && !ready.
  - sq_pop=0 and flush_req is ignored.
  - l1_req_ready=1 → clear mask and timer; go IDLE. l1_req_valid drops the next cycle.
- Latency:
  - A lone store accepted in cycle 0 produces l1_req_valid at cycle FLUSH_TIMEOUT+1.
  - Full line or tag change: request valid the cycle after the triggering decision.
- Throughput: at most one pop per cycle. At least one IDLE cycle between back-to-back line issues.
- Mask holes: bytes never written have mask 0. Data in those lanes is don't-care; drive 0 after reset or clear.
- Timer width: $clog2(FLUSH_TIMEOUT)+1 bits; never exceeds FLUSH_TIMEOUT-1.
- Reset mid-ISSUE or mid-MERGE: buffered data is discarded and l1_req_valid drops immediately (async).

Test Plan:
- Single store addr=0x100, data=0xA5, FLUSH_TIMEOUT=16 → l1_req_valid at cycle 17; addr=0x100, mask=0x000000FF, word0=0xA5; drain_idle=1 after ready.
- Four stores 0x120,0x128,0x130,0x138 on consecutive cycles → four pops; one request, addr=0x120, mask=0xFFFFFFFF, issued the cycle after the 4th pop.
- Store 0x100, then head 0x200 → no pop for 0x200; request for 0x100 with mask 0xFF; 0x200 popped in IDLE after ready and becomes the next line.
- Stores 0x108=0x1 then 0x108=0x2, then flush_req → request word1=0x2, mask=0x0000FF00.
- Hold l1_req_ready=0 for 5 cycles in ISSUE while sq_valid=1 → addr/data/mask stable, sq_pop=0 throughout; single acceptance on ready.
- Assert rst_n=0 during ISSUE → l1_req_valid=0 immediately; after release, drain_idle=1 and mask=0.

Source files
------------

// File: rtl/store_drain_wcb.sv
// Write-combining drain stage between the SM LSU store queue and the L1 data cache.
// Merges consecutive same-line stores into a single-entry line buffer, then issues one line write.
module store_drain_wcb #(
    parameter int ADDR_W         = 40,
    parameter int DATA_W         = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int FLUSH_TIMEOUT  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sq_valid,
    input  logic [ADDR_W-1:0]                sq_addr,
    input  logic [DATA_W-1:0]                sq_data,
    output logic                             sq_pop,
    input  logic                             flush_req,
    output logic                             l1_req_valid,
    output logic [ADDR_W-1:0]                l1_req_addr,
    output logic [WORDS_PER_LINE*DATA_W-1:0] l1_req_data,
    output logic [WORDS_PER_LINE*8-1:0]      l1_req_mask,
    input  logic                             l1_req_ready,
    output logic                             drain_idle
);

    localparam int WIDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFFS_W = WIDX_W + 3;
    localparam int TAG_W  = ADDR_W - OFFS_W;
    localparam int TMR_W  = $clog2(FLUSH_TIMEOUT) + 1;
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    localparam int MASK_W = WORDS_PER_LINE * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [LINE_W-1:0]  data_q;
    logic [MASK_W-1:0]  mask_q;
    logic [TMR_W-1:0]   timer_q;

    logic [WIDX_W-1:0]  in_widx;
    logic [TAG_W-1:0]   in_tag;
    logic               same_tag;
    logic [LINE_W-1:0]  merged_data;
    logic [MASK_W-1:0]  lane_mask;
    logic [MASK_W-1:0]  merged_mask;
    logic               addr_lo_unused;

    logic do_load;
    logic do_merge;
    logic do_tick;
    logic do_clear;

    assign in_widx        = sq_addr[3 +: WIDX_W];
    assign in_tag         = sq_addr[ADDR_W-1:OFFS_W];
    assign same_tag       = (in_tag == tag_q);
    assign addr_lo_unused = ^sq_addr[2:0];

    // Buffer contents with the head store folded in; holes stay zero because the buffer is cleared on issue.
    always_comb begin
        merged_data = data_q;
        lane_mask   = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (in_widx == WIDX_W'(i)) begin
                merged_data[i*DATA_W +: DATA_W] = sq_data;
                lane_mask[i*8 +: 8]             = 8'hFF;
            end
        end
        merged_mask = mask_q | lane_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sq_pop   = 1'b0;
        do_load  = 1'b0;
        do_merge = 1'b0;
        do_tick  = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (sq_valid) begin
                    sq_pop  = 1'b1;
                    do_load = 1'b1;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                if (flush_req) begin
                    state_d = ISSUE;
                end else if (sq_valid && !same_tag) begin
                    state_d = ISSUE;
                end else if (sq_valid) begin
                    sq_pop   = 1'b1;
                    do_merge = 1'b1;
                    if (&merged_mask) begin
                        state_d = ISSUE;
                    end
                end else if (timer_q == TMR_W'(FLUSH_TIMEOUT - 1)) begin
                    state_d = ISSUE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            ISSUE: begin
                if (l1_req_ready) begin
                    do_clear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            timer_q <= '0;
        end else if (do_load) begin
            tag_q   <= in_tag;
            data_q  <= merged_data;
            mask_q  <= lane_mask;
            timer_q <= '0;
        end else if (do_merge) begin
            data_q  <= merged_data;
            mask_q  <= merged_mask;
            timer_q <= '0;
        end else if (do_tick) begin
            timer_q <= timer_q + TMR_W'(1);
        end else if (do_clear) begin
            data_q  <= '0;
            mask_q  <= '0;
            timer_q <= '0;
        end
    end

    // The buffer registers only change outside ISSUE, so the request stays stable while stalled.
    assign l1_req_valid = (state_q == ISSUE);
    assign l1_req_addr  = {tag_q, {OFFS_W{1'b0}}};
    assign l1_req_data  = data_q;
    assign l1_req_mask  = mask_q;
    assign drain_idle   = (state_q == IDLE);

endmodule

// File: tb/tb_store_drain_wcb.sv
// Bench for store_drain_wcb: directed line-merge sequences, a vector table and a randomized
// run against a per-word reference model of the write-combining buffer.
module tb_store_drain_wcb;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam int WPL    = 4;
    localparam int FT     = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sq_valid;
    logic [ADDR_W-1:0]   sq_addr;
    logic [DATA_W-1:0]   sq_data;
    logic                sq_pop;
    logic                flush_req;
    logic                l1_req_valid;
    logic [ADDR_W-1:0]   l1_req_addr;
    logic [WPL*DATA_W-1:0] l1_req_data;
    logic [WPL*8-1:0]    l1_req_mask;
    logic                l1_req_ready;
    logic                drain_idle;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    store_drain_wcb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .FLUSH_TIMEOUT(FT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_data(sq_data), .sq_pop(sq_pop),
        .flush_req(flush_req),
        .l1_req_valid(l1_req_valid), .l1_req_addr(l1_req_addr), .l1_req_data(l1_req_data),
        .l1_req_mask(l1_req_mask), .l1_req_ready(l1_req_ready),
        .drain_idle(drain_idle)
    );

    typedef struct {
        int                n;
        logic [3:0][39:0]  addr;
        logic [3:0][63:0]  dat;
        logic [39:0]       exp_addr;
        logic [31:0]       exp_mask;
        logic [255:0]      exp_data;
        int                exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [39:0] a, input logic [63:0] d,
                                 input logic f, input logic r);
        sq_valid     = v;
        sq_addr      = a;
        sq_data      = d;
        flush_req    = f;
        l1_req_ready = r;
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic waitValid(input int bound, output int n);
        n = 0;
        while (!l1_req_valid && n < bound) begin
            tick();
            n++;
        end
        if (!l1_req_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_valid: actual=timeout required=l1_req_valid within %0d cycles", bound);
        end
    endtask

    task automatic acceptRequest();
        l1_req_ready = 1'b1;
        #1;
        tick();
        l1_req_ready = 1'b0;
        flush_req    = 1'b0;
        #1;
    endtask

    // Reference model state: one buffered line tracked as whole words plus written flags.
    int           m_phase;
    logic [34:0]  m_tag;
    logic [63:0]  m_word[4];
    logic [3:0]   m_wv;
    int           m_idle;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [255:0] held_data;
        logic [39:0]  h_addr;
        logic [63:0]  h_data;
        int           gap;
        logic         v, f, r, exp_pop;
        logic [34:0]  t;
        int           w;
        logic [255:0] e_data;
        logic [31:0]  e_mask;

        vecs[0].n = 1; vecs[0].addr[0] = 40'h400; vecs[0].dat[0] = 64'h1111_2222_3333_4444;
        vecs[0].exp_addr = 40'h400; vecs[0].exp_mask = 32'h0000_00FF;
        vecs[0].exp_data = {64'h0, 64'h0, 64'h0, 64'h1111_2222_3333_4444}; vecs[0].exp_lat = 2;

        vecs[1].n = 2; vecs[1].addr[0] = 40'h418; vecs[1].dat[0] = 64'hDDDD;
        vecs[1].addr[1] = 40'h408; vecs[1].dat[1] = 64'hEEEE;
        vecs[1].exp_addr = 40'h400; vecs[1].exp_mask = 32'hFF00_FF00;
        vecs[1].exp_data = {64'hDDDD, 64'h0, 64'hEEEE, 64'h0}; vecs[1].exp_lat = 2;

        vecs[2].n = 2; vecs[2].addr[0] = 40'h510; vecs[2].dat[0] = 64'hA;
        vecs[2].addr[1] = 40'h510; vecs[2].dat[1] = 64'hB;
        vecs[2].exp_addr = 40'h500; vecs[2].exp_mask = 32'h00FF_0000;
        vecs[2].exp_data = {64'h0, 64'hB, 64'h0, 64'h0}; vecs[2].exp_lat = 2;

        vecs[3].n = 4; vecs[3].addr[0] = 40'h638; vecs[3].dat[0] = 64'h33;
        vecs[3].addr[1] = 40'h630; vecs[3].dat[1] = 64'h22;
        vecs[3].addr[2] = 40'h628; vecs[3].dat[2] = 64'h11;
        vecs[3].addr[3] = 40'h620; vecs[3].dat[3] = 64'hF0;
        vecs[3].exp_addr = 40'h620; vecs[3].exp_mask = 32'hFFFF_FFFF;
        vecs[3].exp_data = {64'h33, 64'h22, 64'h11, 64'hF0}; vecs[3].exp_lat = 1;

        vecs[4].n = 1; vecs[4].addr[0] = 40'hFF_FFFF_FFE8; vecs[4].dat[0] = 64'hCAFE;
        vecs[4].exp_addr = 40'hFF_FFFF_FFE0; vecs[4].exp_mask = 32'h0000_FF00;
        vecs[4].exp_data = {64'h0, 64'h0, 64'hCAFE, 64'h0}; vecs[4].exp_lat = 2;

        vecs[5].n = 3; vecs[5].addr[0] = 40'h7F0; vecs[5].dat[0] = 64'h5;
        vecs[5].addr[1] = 40'h7E0; vecs[5].dat[1] = 64'h6;
        vecs[5].addr[2] = 40'h7F0; vecs[5].dat[2] = 64'h7;
        vecs[5].exp_addr = 40'h7E0; vecs[5].exp_mask = 32'h00FF_00FF;
        vecs[5].exp_data = {64'h0, 64'h7, 64'h0, 64'h6}; vecs[5].exp_lat = 2;

        rst_n = 1'b0;
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("reset_valid", l1_req_valid, 0);
        checkOutput("reset_addr", l1_req_addr, 0);
        checkOutput("reset_data", l1_req_data, 0);
        checkOutput("reset_mask", l1_req_mask, 0);
        checkOutput("reset_pop", sq_pop, 0);
        checkOutput("reset_idle", drain_idle, 1);
        resetDut();

        // Lone store closed by the idle timeout.
        applyStimulus(1, 40'h100, 64'hA5, 0, 0);
        checkOutput("single_pop", sq_pop, 1);
        tick();
        applyStimulus(0, '0, '0, 0, 0);
        waitValid(40, n);
        checkOutput("single_latency", 1 + n, 17);
        checkOutput("single_addr", l1_req_addr, 40'h100);
        checkOutput("single_mask", l1_req_mask, 32'h0000_00FF);
        checkOutput("single_data", l1_req_data, {192'h0, 64'hA5});
        acceptRequest();
        checkOutput("single_idle_after", drain_idle, 1);
        checkOutput("single_valid_drop", l1_req_valid, 0);

        // Full line from four consecutive stores.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 40'h120 + 40'(8 * i), 64'h1000 + 64'(i), 0, 0);
            checkOutput("full_pop", sq_pop, 1);
            tick();
        end
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("full_valid_next", l1_req_valid, 1);
        checkOutput("full_addr", l1_req_addr, 40'h120);
        checkOutput("full_mask", l1_req_mask, 32'hFFFF_FFFF);
        checkOutput("full_data", l1_req_data, {64'h1003, 64'h1002, 64'h1001, 64'h1000});
        acceptRequest();

        // Tag change leaves the new store at the head until the buffer drains.
        applyStimulus(1, 40'h100, 64'h11, 0, 0);
        checkOutput("tagchg_pop0", sq_pop, 1);
        tick();
        applyStimulus(1, 40'h200, 64'h22, 0, 0);
        checkOutput("tagchg_nopop", sq_pop, 0);
        tick();
        checkOutput("tagchg_valid", l1_req_valid, 1);
        checkOutput("tagchg_pop_issue", sq_pop, 0);
        checkOutput("tagchg_addr", l1_req_addr, 40'h100);
        checkOutput("tagchg_mask", l1_req_mask, 32'h0000_00FF);
        acceptRequest();
        checkOutput("tagchg_idle", drain_idle, 1);
        checkOutput("tagchg_pop_new", sq_pop, 1);
        tick();
        applyStimulus(0, '0, '0, 1, 0);
        tick();
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("tagchg2_valid", l1_req_valid, 1);
        checkOutput("tagchg2_addr", l1_req_addr, 40'h200);
        checkOutput("tagchg2_data", l1_req_data, {192'h0, 64'h22});
        acceptRequest();

        // Same word written twice, then flushed.
        applyStimulus(1, 40'h108, 64'h1, 0, 0);
        tick();
        applyStimulus(1, 40'h108, 64'h2, 0, 0);
        checkOutput("ovw_pop", sq_pop, 1);
        tick();
        applyStimulus(0, '0, '0, 1, 0);
        tick();
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("ovw_valid", l1_req_valid, 1);
        checkOutput("ovw_mask", l1_req_mask, 32'h0000_FF00);
        checkOutput("ovw_data", l1_req_data, {128'h0, 64'h2, 64'h0});
        acceptRequest();

        // Stalled request must hold while a different-line store waits.
        applyStimulus(1, 40'h140, 64'hAA, 0, 0);
        tick();
        applyStimulus(1, 40'h148, 64'hBB, 0, 0);
        tick();
        applyStimulus(1, 40'h300, 64'hCC, 0, 0);
        tick();
        held_data = {128'h0, 64'hBB, 64'hAA};
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_valid", l1_req_valid, 1);
            checkOutput("stall_addr", l1_req_addr, 40'h140);
            checkOutput("stall_mask", l1_req_mask, 32'h0000_FFFF);
            checkOutput("stall_data", l1_req_data, held_data);
            checkOutput("stall_pop", sq_pop, 0);
            tick();
        end
        acceptRequest();
        checkOutput("stall_single_accept", l1_req_valid, 0);
        checkOutput("stall_pop_after", sq_pop, 1);
        tick();
        applyStimulus(0, '0, '0, 1, 0);
        tick();
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("stall2_addr", l1_req_addr, 40'h300);
        acceptRequest();

        // Asynchronous reset while a request is pending.
        applyStimulus(1, 40'h700, 64'h77, 0, 0);
        tick();
        applyStimulus(0, '0, '0, 1, 0);
        tick();
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("rstmid_valid_before", l1_req_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_valid", l1_req_valid, 0);
        checkOutput("rstmid_idle", drain_idle, 1);
        checkOutput("rstmid_mask", l1_req_mask, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rstmid_idle_after", drain_idle, 1);
        checkOutput("rstmid_mask_after", l1_req_mask, 0);

        // Vector table: stores, then a flush the cycle after the last pop.
        for (int vi = 0; vi < 6; vi++) begin
            for (int j = 0; j < vecs[vi].n; j++) begin
                applyStimulus(1, vecs[vi].addr[j], vecs[vi].dat[j], 0, 0);
                checkOutput("vec_pop", sq_pop, 1);
                tick();
            end
            applyStimulus(0, '0, '0, 1, 0);
            waitValid(5, n);
            checkOutput("vec_latency", 1 + n, vecs[vi].exp_lat);
            checkOutput("vec_addr", l1_req_addr, vecs[vi].exp_addr);
            checkOutput("vec_mask", l1_req_mask, vecs[vi].exp_mask);
            checkOutput("vec_data", l1_req_data, vecs[vi].exp_data);
            acceptRequest();
            checkOutput("vec_idle", drain_idle, 1);
        end

        // Randomized traffic against the reference model.
        resetDut();
        m_phase = 0; m_tag = '0; m_wv = '0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_word[i] = '0;
        gap = 0;
        h_addr = 40'h1000 + 40'(8 * $urandom_range(0, 3)) + 40'($urandom_range(0, 7));
        h_data = {$urandom, $urandom};
        for (int c = 0; c < 3000; c++) begin
            if (gap > 0) begin
                v = 1'b0;
                gap--;
            end else begin
                v = ($urandom_range(0, 99) < 75);
                if ($urandom_range(0, 99) < 3) gap = $urandom_range(10, 20);
            end
            f = ($urandom_range(0, 99) < 8);
            r = ($urandom_range(0, 99) < 50);
            applyStimulus(v, h_addr, h_data, f, r);

            t = h_addr[39:5];
            w = int'(h_addr[4:3]);
            exp_pop = v && (m_phase == 0 || (m_phase == 1 && !f && t == m_tag));
            checkOutput("rand_pop", sq_pop, exp_pop);
            checkOutput("rand_valid", l1_req_valid, (m_phase == 2));
            checkOutput("rand_idle", drain_idle, (m_phase == 0));
            if (m_phase == 2) begin
                e_data = '0;
                e_mask = '0;
                for (int k = 0; k < 4; k++) begin
                    if (m_wv[k]) begin
                        e_data[k*64 +: 64] = m_word[k];
                        e_mask[k*8 +: 8]   = 8'hFF;
                    end
                end
                checkOutput("rand_addr", l1_req_addr, {m_tag, 5'b0});
                checkOutput("rand_mask", l1_req_mask, e_mask);
                checkOutput("rand_data", l1_req_data, e_data);
            end

            case (m_phase)
                0: begin
                    if (v) begin
                        m_tag = t;
                        m_wv = '0;
                        m_word[w] = h_data;
                        m_wv[w] = 1'b1;
                        m_idle = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (f || (v && t != m_tag)) begin
                        m_phase = 2;
                    end else if (v) begin
                        m_word[w] = h_data;
                        m_wv[w] = 1'b1;
                        m_idle = 0;
                        if (m_wv == 4'hF) m_phase = 2;
                    end else begin
                        m_idle++;
                        if (m_idle == FT) m_phase = 2;
                    end
                end
                default: begin
                    if (r) begin
                        m_phase = 0;
                        m_wv = '0;
                        for (int k = 0; k < 4; k++) m_word[k] = '0;
                    end
                end
            endcase

            if (exp_pop) begin
                case ($urandom_range(0, 2))
                    0: h_addr = 40'h1000;
                    1: h_addr = 40'h1020;
                    default: h_addr = 40'h2000;
                endcase
                h_addr = h_addr + 40'(8 * $urandom_range(0, 3)) + 40'($urandom_range(0, 7));
                h_data = {$urandom, $urandom};
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
